// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller: movement command codes,
// controller state enum and default building size.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF    = 4;

    localparam logic [1:0] CMD_WAIT = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_DOWN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } fsm_e;

endpackage

// File: rtl/elevator_dir_select.sv
// Combinational SCAN direction chooser: classifies outstanding calls relative
// to a floor and picks the next movement, preferring the current sweep direction.
module elevator_dir_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  dir_up_i,
    output logic                  here_o,
    output logic                  above_o,
    output logic                  below_o,
    output logic [1:0]            next_cmd_o
);

    always_comb begin
        here_o  = 1'b0;
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == cur_floor_i) begin
                here_o = here_o | pending_i[i];
            end else if (FLOOR_W'(i) > cur_floor_i) begin
                above_o = above_o | pending_i[i];
            end else begin
                below_o = below_o | pending_i[i];
            end
        end

        next_cmd_o = CMD_WAIT;
        if (dir_up_i) begin
            if (above_o)      next_cmd_o = CMD_UP;
            else if (below_o) next_cmd_o = CMD_DOWN;
        end else begin
            if (below_o)      next_cmd_o = CMD_DOWN;
            else if (above_o) next_cmd_o = CMD_UP;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car controller: latches floor calls, owns car position and sequences
// SCAN movement, travel timing and door-open timing.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_FLOORS-1:0] call_i,
    output logic [FLOOR_W-1:0]    cur_floor_o,
    output logic [1:0]            state_o,
    output logic                  door_open_o,
    output logic                  dir_up_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  arrive_o
);

    localparam int TW = $clog2(TRAVEL_CYCLES) + 1;
    localparam int DW = $clog2(DOOR_CYCLES) + 1;

    fsm_e                  fsm_q, fsm_d;
    logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]         travel_q, travel_d;
    logic [DW-1:0]         door_q, door_d;
    logic                  dir_up_q, dir_up_d;
    logic                  arrive_q, arrive_d;
    logic [1:0]            state_q, state_d;
    logic                  door_open_q, door_open_d;

    logic [NUM_FLOORS-1:0] cur_onehot, clear, sel_pend;
    logic [FLOOR_W-1:0]    sel_floor;
    logic                  moving, here, above, below;
    logic [1:0]            next_cmd;
    fsm_e                  decided;

    // While moving, the decision is taken for the floor being reached and must
    // see calls arriving on that same edge; otherwise it is taken at the current floor.
    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == cur_floor_q) cur_onehot[i] = 1'b1;
        end
        clear     = (fsm_q == S_DOOR) ? cur_onehot : '0;
        moving    = (fsm_q == S_MOVE_UP) || (fsm_q == S_MOVE_DOWN);
        sel_floor = cur_floor_q;
        if (fsm_q == S_MOVE_UP)   sel_floor = cur_floor_q + 1'b1;
        if (fsm_q == S_MOVE_DOWN) sel_floor = cur_floor_q - 1'b1;
        sel_pend  = moving ? (pending_q | call_i) : (pending_q & ~clear);
    end

    elevator_dir_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_dir_select (
        .pending_i   (sel_pend),
        .cur_floor_i (sel_floor),
        .dir_up_i    (dir_up_q),
        .here_o      (here),
        .above_o     (above),
        .below_o     (below),
        .next_cmd_o  (next_cmd)
    );

    assign decided = here              ? S_DOOR :
                     !(above || below) ? S_IDLE :
                     (next_cmd == CMD_UP) ? S_MOVE_UP : S_MOVE_DOWN;

    always_comb begin
        fsm_d       = fsm_q;
        cur_floor_d = cur_floor_q;
        travel_d    = travel_q;
        door_d      = door_q;
        dir_up_d    = dir_up_q;
        arrive_d    = 1'b0;
        pending_d   = (pending_q | call_i) & ~clear;

        case (fsm_q)
            S_IDLE: fsm_d = decided;
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                    travel_d    = '0;
                    cur_floor_d = sel_floor;
                    arrive_d    = 1'b1;
                    fsm_d       = decided;
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            S_DOOR: begin
                // A new press for this floor holds the door open instead of queueing.
                if (|(call_i & cur_onehot)) begin
                    door_d = '0;
                end else if (door_q == DW'(DOOR_CYCLES - 1)) begin
                    door_d = '0;
                    fsm_d  = decided;
                end else begin
                    door_d = door_q + 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (fsm_d == S_MOVE_UP)        dir_up_d = 1'b1;
        else if (fsm_d == S_MOVE_DOWN) dir_up_d = 1'b0;

        state_d = CMD_WAIT;
        if (fsm_d == S_MOVE_UP)   state_d = CMD_UP;
        if (fsm_d == S_MOVE_DOWN) state_d = CMD_DOWN;
        door_open_d = (fsm_d == S_DOOR);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q       <= S_IDLE;
            cur_floor_q <= '0;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
            dir_up_q    <= 1'b1;
            arrive_q    <= 1'b0;
            state_q     <= CMD_WAIT;
            door_open_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
            dir_up_q    <= dir_up_d;
            arrive_q    <= arrive_d;
            state_q     <= state_d;
            door_open_q <= door_open_d;
        end
    end

    assign cur_floor_o = cur_floor_q;
    assign state_o     = state_q;
    assign door_open_o = door_open_q;
    assign dir_up_o    = dir_up_q;
    assign pending_o   = pending_q;
    assign arrive_o    = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: hand-derived vector table, SCAN
// corner sequences and random calls against a floor-level behavioural model.
module tb_elevator_scheduler;

    localparam int TRAVEL = 4;
    localparam int DOORC  = 6;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] call = 8'h00;
    logic [3:0] cur_floor;
    logic [1:0] state;
    logic       door_open, dir_up, arrive;
    logic [7:0] pending;

    int nChecks = 0;
    int nFails  = 0;

    int         mFloor, mMode, mLeft;
    bit         mDirUp, mArrive;
    logic [7:0] mPend;

    int stops[$];
    bit prevDoor;

    typedef struct {
        logic [7:0] call;
        logic [1:0] st;
        int         floor;
        logic       door;
        logic [7:0] pend;
        logic       arr;
    } vec_t;
    vec_t tbl[20];

    elevator_scheduler #(
        .NUM_FLOORS    (8),
        .FLOOR_W       (4),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOORC)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .call_i      (call),
        .cur_floor_o (cur_floor),
        .state_o     (state),
        .door_open_o (door_open),
        .dir_up_o    (dir_up),
        .pending_o   (pending),
        .arrive_o    (arrive)
    );

    always #5 clk = ~clk;

    // SCAN choice at a floor, from the rules: serve here, else keep sweeping, else reverse.
    function automatic int pick(input logic [7:0] p, input int fl, input bit up);
        bit hasAbove = 0, hasBelow = 0;
        for (int i = 0; i < 8; i++) begin
            if (p[i] && i > fl) hasAbove = 1;
            if (p[i] && i < fl) hasBelow = 1;
        end
        if (p[fl]) return M_DOOR;
        if (up) return hasAbove ? M_UP : (hasBelow ? M_DOWN : M_IDLE);
        return hasBelow ? M_DOWN : (hasAbove ? M_UP : M_IDLE);
    endfunction

    task automatic modelReset();
        mFloor = 0; mMode = M_IDLE; mLeft = 0; mDirUp = 1; mArrive = 0; mPend = 8'h00;
    endtask

    task automatic modelStep(input logic [7:0] c);
        logic [7:0] atFloor;
        logic [7:0] newPend;
        int nxt;
        atFloor = 8'h01 << mFloor;
        newPend = mPend | c;
        if (mMode == M_DOOR) newPend = newPend & ~atFloor;
        mArrive = 0;
        nxt = mMode;
        case (mMode)
            M_IDLE: nxt = pick(mPend, mFloor, mDirUp);
            M_UP, M_DOWN: begin
                mLeft--;
                if (mLeft == 0) begin
                    mFloor  = mFloor + ((mMode == M_UP) ? 1 : -1);
                    mArrive = 1;
                    nxt = pick(mPend | c, mFloor, mDirUp);
                    if (nxt == M_UP || nxt == M_DOWN) mLeft = TRAVEL;
                end
            end
            default: begin
                if (c[mFloor]) mLeft = DOORC;
                else begin
                    mLeft--;
                    if (mLeft == 0) nxt = pick(mPend & ~atFloor, mFloor, mDirUp);
                end
            end
        endcase
        if (nxt != mMode) begin
            if (nxt == M_DOOR) mLeft = DOORC;
            if (nxt == M_UP || nxt == M_DOWN) mLeft = TRAVEL;
        end
        if (nxt == M_UP)   mDirUp = 1;
        if (nxt == M_DOWN) mDirUp = 0;
        mMode = nxt;
        mPend = newPend;
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput();
        int expState;
        expState = (mMode == M_UP) ? 2 : (mMode == M_DOWN) ? 3 : 0;
        checkVal("cur_floor", int'(cur_floor), mFloor);
        checkVal("state", int'(state), expState);
        checkVal("door_open", int'(door_open), int'(mMode == M_DOOR));
        checkVal("dir_up", int'(dir_up), int'(mDirUp));
        checkVal("pending", int'(pending), int'(mPend));
        checkVal("arrive", int'(arrive), int'(mArrive));
        checkVal("no_up_at_top", int'(state == 2'b10 && cur_floor == 4'd7), 0);
        checkVal("no_down_at_ground", int'(state == 2'b11 && cur_floor == 4'd0), 0);
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        call = c;
        @(posedge clk);
        modelStep(c);
        #1;
        checkOutput();
        if (door_open && !prevDoor) stops.push_back(int'(cur_floor));
        prevDoor = door_open;
        call = 8'h00;
    endtask

    task automatic resetDut();
        call = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("rst_cur_floor", int'(cur_floor), 0);
        checkVal("rst_state", int'(state), 0);
        checkVal("rst_door", int'(door_open), 0);
        checkVal("rst_dir_up", int'(dir_up), 1);
        checkVal("rst_pending", int'(pending), 0);
        checkVal("rst_arrive", int'(arrive), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stops.delete();
        prevDoor = 0;
    endtask

    task automatic waitFloor(input int f, input int budget);
        int n = 0;
        while (int'(cur_floor) != f && n < budget) begin
            applyStimulus(8'h00);
            n++;
        end
        checkVal("wait_floor", int'(cur_floor), f);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((state != 2'b00 || door_open || pending != 8'h00) && n < budget) begin
            applyStimulus(8'h00);
            n++;
        end
        checkVal("drain_pending", int'(pending), 0);
        checkVal("drain_door", int'(door_open), 0);
    endtask

    task automatic checkStops(input string name, input int a, input int b);
        checkVal({name, "_count"}, stops.size(), 2);
        if (stops.size() >= 1) checkVal({name, "_first"}, stops[0], a);
        if (stops.size() >= 2) checkVal({name, "_second"}, stops[1], b);
    endtask

    initial begin
        int doorLen;
        logic [7:0] c;

        for (int k = 0; k < 20; k++) begin
            tbl[k].call  = (k == 0) ? 8'h08 : 8'h00;
            tbl[k].st    = (k >= 1 && k <= 12) ? 2'b10 : 2'b00;
            tbl[k].floor = (k < 5) ? 0 : (k < 9) ? 1 : (k < 13) ? 2 : 3;
            tbl[k].door  = (k >= 13 && k <= 18);
            tbl[k].pend  = (k <= 13) ? 8'h08 : 8'h00;
            tbl[k].arr   = (k == 5 || k == 9 || k == 13);
        end

        modelReset();
        #1 rst_n = 1'b0;
        resetDut();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(8'h00);
            checkVal("idle_no_calls", int'(state), 0);
        end

        $display("[TB] single call table");
        resetDut();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(tbl[k].call);
            checkVal("tbl_state", int'(state), int'(tbl[k].st));
            checkVal("tbl_floor", int'(cur_floor), tbl[k].floor);
            checkVal("tbl_door", int'(door_open), int'(tbl[k].door));
            checkVal("tbl_pending", int'(pending), int'(tbl[k].pend));
            checkVal("tbl_arrive", int'(arrive), int'(tbl[k].arr));
        end

        $display("[TB] pass-through stop");
        resetDut();
        applyStimulus(8'h40);
        waitFloor(2, 100);
        applyStimulus(8'h10);
        waitIdle(300);
        checkStops("pass_stops", 4, 6);

        $display("[TB] SCAN reversal");
        resetDut();
        applyStimulus(8'h20);
        waitFloor(3, 100);
        applyStimulus(8'h02);
        waitIdle(300);
        checkStops("scan_stops", 5, 1);
        checkVal("scan_final_dir", int'(dir_up), 0);

        $display("[TB] same-floor call");
        resetDut();
        applyStimulus(8'h04);
        waitIdle(200);
        checkVal("same_at_floor", int'(cur_floor), 2);
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        checkVal("same_door_after_2", int'(door_open), 1);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00);
        applyStimulus(8'h04);
        checkVal("same_pending_bit", int'(pending[2]), 0);
        doorLen = 1;
        while (door_open && doorLen < 40) begin
            applyStimulus(8'h00);
            if (door_open) doorLen++;
        end
        checkVal("same_door_extend", doorLen, 6);

        $display("[TB] async reset mid-move");
        resetDut();
        applyStimulus(8'h80);
        waitFloor(3, 100);
        checkVal("pre_rst_state", int'(state), 2);
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("amid_cur_floor", int'(cur_floor), 0);
        checkVal("amid_state", int'(state), 0);
        checkVal("amid_dir_up", int'(dir_up), 1);
        checkVal("amid_pending", int'(pending), 0);
        checkVal("amid_door", int'(door_open), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prevDoor = 0;
        for (int k = 0; k < 10; k++) applyStimulus(8'h00);

        $display("[TB] random calls");
        resetDut();
        for (int k = 0; k < 3000; k++) begin
            c = 8'h00;
            if ($urandom_range(0, 5) == 0) c = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 40) == 0) c = 8'($urandom);
            applyStimulus(c);
        end
        waitIdle(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
